// File: rtl/fwd_hazard_unit_pkg.sv
// Shared encodings for the EX-stage hazard block: operand mux selects and scoreboard states.
package fwd_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_hazard_unit_sel_lane.sv
// One operand's forwarding select: EX/MEM beats MEM/WB, register x0 never forwards.
module fwd_sel_lane
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_regwrite,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_regwrite,
  output logic [1:0]        sel
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == src);
  assign memwb_hit = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == src);

  always_comb begin
    sel = FWD_REG;
    if (exmem_hit) begin
      sel = FWD_EXMEM;
    end else if (memwb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage hazard unit: operand forwarding, load-use stall and a single-entry multiplier scoreboard.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MUL_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      id_ex_memread,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      ex_mem_regwrite,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic                      mem_wb_regwrite,
  input  logic                      mul_start,
  input  logic [REG_AW-1:0]         mul_rd,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      flush_ex,
  output logic                      mul_busy,
  output logic                      mul_done
);

  localparam int CNT_W = $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [REG_AW-1:0] mul_rd_q;

  logic lu_hz;
  logic raw_hz;
  logic struct_hz;
  logic accept;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    fwd_sel_lane #(
      .REG_AW (REG_AW)
    ) u_lane (
      .src             (ex_src[i*REG_AW +: REG_AW]),
      .ex_mem_rd       (ex_mem_rd),
      .ex_mem_regwrite (ex_mem_regwrite),
      .mem_wb_rd       (mem_wb_rd),
      .mem_wb_regwrite (mem_wb_regwrite),
      .sel             (fwd_sel[i*2 +: 2])
    );
  end

  // Both hazards compare the same ID sources, just against different producers.
  always_comb begin
    lu_hz  = 1'b0;
    raw_hz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_ex_memread && (id_ex_rd != '0) && (id_ex_rd == id_src[i*REG_AW +: REG_AW])) begin
        lu_hz = 1'b1;
      end
      if (mul_busy && (mul_rd_q != '0) && (mul_rd_q == id_src[i*REG_AW +: REG_AW])) begin
        raw_hz = 1'b1;
      end
    end
  end

  assign mul_busy  = (state == BUSY);
  assign struct_hz = mul_busy && mul_start;
  assign stall     = lu_hz | raw_hz | struct_hz;
  assign flush_ex  = stall;
  assign accept    = mul_start && !stall;

  // mul_done is raised on the edge leaving cnt==1 so it lands on the final BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mul_rd_q <= '0;
      mul_done <= 1'b0;
    end else begin
      mul_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= BUSY;
            mul_rd_q <= mul_rd;
            cnt      <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt == CNT_ONE) begin
            mul_done <= 1'b1;
          end
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Next-generation EX-stage hazard block for the 5-stage pipeline.
- Generalises operand forwarding to NUM_SRC source operands and a parametrised register-address width.
- Adds load-use stall detection and a sequential scoreboard for one multi-cycle multiplier. The scoreboard stalls ID on RAW and structural conflicts until the multiply completes.
- Sits beside the ID/EX register. It drives the EX operand muxes, the PC/IF_ID write enables (through stall) and the ID_EX bubble (through flush_ex).

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction (ID and EX both carry NUM_SRC).
- MUL_LAT, 4, multiplier latency in cycles from accepted start to mul_done (legal range 2..16).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- id_src  in  NUM_SRC*REG_AW  IF_ID source regs; operand i is at bits [i*REG_AW +: REG_AW].
- ex_src  in  NUM_SRC*REG_AW  ID_EX source regs, same packing.
- id_ex_rd  in  REG_AW  ID_EX destination.
- id_ex_memread  in  1  ID_EX instruction is a load.
- ex_mem_rd  in  REG_AW  EX_MEM destination.
- ex_mem_regwrite  in  1  EX_MEM writes a register.
- mem_wb_rd  in  REG_AW  MEM_WB destination.
- mem_wb_regwrite  in  1  MEM_WB writes a register.
- mul_start  in  1  instruction in ID is a multi-cycle multiply.
- mul_rd  in  REG_AW  destination of that multiply.
- fwd_sel  out  NUM_SRC*2  per-operand mux select, packed [i*2 +: 2].
- stall  out  1  hold PC and IF_ID.
- flush_ex  out  1  insert bubble into ID_EX (equals stall).
- mul_busy  out  1  scoreboard occupied.
- mul_done  out  1  one-cycle pulse on the multiply's final cycle.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, counter 0, mul_rd_q 0, mul_done 0, mul_busy 0. While reset is asserted, fwd_sel, stall and flush_ex are purely combinational from the inputs (stall from load-use only).
- Forwarding (combinational, per operand i, s = ex_src[i]):
  - 2'b10 if ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == s.
  - Otherwise 2'b01 if mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == s.
  - Otherwise 2'b00.
  - The EX/MEM match always wins, and the MEM/WB condition is evaluated only when the EX/MEM condition is false. A non-writing EX/MEM stage never blocks MEM/WB forwarding.
  - s == 0 always yields 2'b00.
- Load-use hazard: lu = id_ex_memread && id_ex_rd != 0 && id_ex_rd equals any id_src[i].
- Scoreboard FSM:
  - States: IDLE, BUSY; counter width $clog2(MUL_LAT).
  - Acceptance: accept = mul_start && !stall.
  - IDLE + accept: go to BUSY, mul_rd_q <= mul_rd, cnt <= MUL_LAT-1.
  - BUSY: cnt decrements each cycle. When cnt == 1, mul_done <= 1 next cycle (the cycle with cnt == 0). At cnt == 0, go to IDLE.
  - mul_busy = (state == BUSY).
- Scoreboard hazards:
  - raw = mul_busy && mul_rd_q != 0 && mul_rd_q equals any id_src[i].
  - struct = mul_busy && mul_start.
- Stall outputs: stall = lu | raw | struct; flush_ex = stall.
- Boundary conditions:
  - mul_rd == 0: the multiply is accepted and occupies the unit; it causes no RAW stall.
  - Cycle with mul_done = 1: the unit is still BUSY, so dependents remain stalled and are released the next cycle. A mul_start in that cycle is stalled and accepted the following cycle.
  - mul_start coinciding with lu: not accepted; the FSM stays IDLE.
  - Reset asserted while BUSY: returns to IDLE immediately, with no mul_done pulse.
  - Multiply result writeback is the datapath's job via MEM/WB; this block does not forward it.

Decomposition:
- Package fwd_pkg holds:
  - FWD_REG = 2'b00, FWD_MEMWB = 2'b01, FWD_EXMEM = 2'b10;
  - state enum {IDLE, BUSY}.
- Sub-module fwd_sel_lane: one operand's combinational select, instantiated NUM_SRC times via generate.
- The scoreboard FSM stays in the top module.

Test Plan:
- ex_src[0] = 3; ex_mem_rd = 3, regwrite = 1; mem_wb_rd = 3, regwrite = 1 -> fwd_sel[1:0] = 2'b10. Drop ex_mem_regwrite -> 2'b01.
- ex_src[1] = 0 with ex_mem_rd = 0, regwrite = 1 -> fwd_sel[3:2] = 2'b00.
- id_ex_memread = 1, id_ex_rd = 7, id_src[1] = 7 -> stall = flush_ex = 1 for exactly that cycle. Same inputs with id_ex_rd = 0 -> stall = 0.
- MUL_LAT = 4: mul_start, mul_rd = 9 at cycle 0; id_src[0] = 9 from cycle 1 -> mul_busy cycles 1-4, mul_done only at cycle 4, stall cycles 1-4, stall = 0 at cycle 5.
- While BUSY: second mul_start -> stall = 1 until the cycle after mul_done, then accepted (mul_busy = 1 again, mul_rd_q updated).
- rst_n low at cycle 2 of a multiply -> mul_busy = 0 and stall = 0 immediately (id_ex_memread = 0), no mul_done. After release, a new mul_start is accepted in the same cycle.
